signal_block_averager: RTL and testbench



---
 rtl/signal_block_averager.sv | 137 +++++++++++++
 tb/tb_signal_block_averager.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_block_averager.sv
// signal_block_averager
//
// Block-averaging decimator placed after the A/B signal selector. Signed
// samples are summed over non-overlapping blocks of 2^Neff samples, where
// Neff = min(log2_ratio, MAX_LOG2_RATIO) is captured at the start of each
// block. One arithmetic-shifted average per block is emitted on an
// AXI-Stream-style master port.
//
// Ports:
//   aclk           system clock, rising edge
//   areset         asynchronous active-high reset
//   log2_ratio     requested block exponent (block length 2^N samples)
//   s_axis_tdata   signed input sample
//   s_axis_tvalid  input sample valid
//   s_axis_tready  0 in reset, 1 from the first cycle after release
//   m_axis_tdata   signed block average
//   m_axis_tvalid  output valid
//   m_axis_tready  downstream ready
//   overflow       sticky: a pending result was overwritten before acceptance
//   clear_overflow synchronous clear of overflow (a coinciding set wins)
//   state_dbg      current FSM state (0 = LOAD, 1 = ACCUM)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The slave side never stalls once out of reset. On the master side
// m_axis_tvalid/m_axis_tdata hold until a transfer, except that a newly
// completed block always replaces the pending value (flagged via overflow
// when the old value was not taken on that same edge).

module signal_block_averager #(
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_LOG2_RATIO = 8,
  parameter int RATIO_WIDTH    = 4
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [RATIO_WIDTH-1:0] log2_ratio,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   overflow,
  input  logic                   clear_overflow,
  output logic                   state_dbg
);

  localparam int AW = DATA_WIDTH + MAX_LOG2_RATIO;
  localparam int CW = MAX_LOG2_RATIO + 1;
  localparam logic [RATIO_WIDTH-1:0] MAX_R = RATIO_WIDTH'(MAX_LOG2_RATIO);

  typedef enum logic {
    LOAD  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                  state;
  logic signed [AW-1:0]    acc;
  logic [CW-1:0]           count;
  logic [RATIO_WIDTH-1:0]  neff;

  logic [RATIO_WIDTH-1:0]  neff_in;
  logic [RATIO_WIDTH-1:0]  shift_now;
  logic signed [AW-1:0]    sample_ext;
  logic signed [AW-1:0]    sum_now;
  logic [CW-1:0]           cnt_now;
  logic [CW-1:0]           blk_len;
  logic [DATA_WIDTH-1:0]   result;
  logic                    accept;
  logic                    done;
  logic                    ovf_event;

  assign state_dbg = (state == ACCUM);

  // The sum, count and shift that apply once the current sample is included.
  // In LOAD the sample starts a new block with a freshly clamped exponent; in
  // ACCUM it extends the running block under the latched exponent.
  always_comb begin
    neff_in    = (log2_ratio > MAX_R) ? MAX_R : log2_ratio;
    sample_ext = {{MAX_LOG2_RATIO{s_axis_tdata[DATA_WIDTH-1]}}, s_axis_tdata};
    if (state == LOAD) begin
      sum_now   = sample_ext;
      shift_now = neff_in;
      cnt_now   = CW'(1);
    end else begin
      sum_now   = acc + sample_ext;
      shift_now = neff;
      cnt_now   = count + CW'(1);
    end
    blk_len   = CW'(1) << shift_now;
    accept    = s_axis_tvalid & s_axis_tready;
    done      = accept && (cnt_now == blk_len);
    // Arithmetic shift at full accumulator width, then keep the low bits;
    // the average of in-range samples always fits DATA_WIDTH.
    result    = DATA_WIDTH'(sum_now >>> shift_now);
    ovf_event = done && m_axis_tvalid && !m_axis_tready;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= LOAD;
      acc           <= '0;
      count         <= '0;
      neff          <= '0;
      s_axis_tready <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      s_axis_tready <= 1'b1;

      // Cycles without an accepted sample hold the block state.
      if (accept) begin
        acc   <= sum_now;
        count <= cnt_now;
        if (state == LOAD) begin
          neff <= neff_in;
        end
        state <= done ? LOAD : ACCUM;
      end

      if (done) begin
        m_axis_tdata  <= result;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      if (ovf_event) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_signal_block_averager.sv
module tb_signal_block_averager;

  logic        aclk;
  logic        areset;
  logic [3:0]  log2_ratio;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        overflow;
  logic        clear_overflow;
  logic        state_dbg;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  signal_block_averager dut (
    .aclk           (aclk),
    .areset         (areset),
    .log2_ratio     (log2_ratio),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- driver tasks ----------------
  // Inputs change 1 ns after a rising edge and stay stable until the next.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [15:0] v);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = v;
    step();
  endtask

  // ---------------- scoreboard ----------------
  // Sampled on the falling edge: a valid&ready seen here is the transfer
  // that the following rising edge performs.
  always @(negedge aclk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      logic [15:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected got %0d expected none", $signed(m_axis_tdata));
      end else begin
        e = exp_q.pop_front();
        if (m_axis_tdata !== e) begin
          errors++;
          $display("FAIL out_data got %0d expected %0d", $signed(m_axis_tdata), $signed(e));
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    areset = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 16'd100;
    step(); step();
    checks++;
    if (m_axis_tdata !== 16'd0 || m_axis_tvalid !== 1'b0 || overflow !== 1'b0 ||
        s_axis_tready !== 1'b0 || state_dbg !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got tdata=%0d tvalid=%b ovf=%b tready=%b st=%b expected 0 0 0 0 0",
               m_axis_tdata, m_axis_tvalid, overflow, s_axis_tready, state_dbg);
    end
    s_axis_tvalid = 1'b0;
    areset = 1'b0;
    step();
    checks++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got tready=%b tvalid=%b expected 1 0", s_axis_tready, m_axis_tvalid);
    end
    idle(3);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_output got tvalid=%b expected 0", m_axis_tvalid);
    end
  endtask

  task automatic test_basic();
    log2_ratio = 4'd2; m_axis_tready = 1'b1;
    exp_q.push_back(-16'sd8);
    send(16'sd14); send(16'sd14); send(-16'sd29);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early got tvalid=%b expected 0", m_axis_tvalid);
    end
    send(-16'sd29);
    s_axis_tvalid = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b1 || state_dbg !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency got tvalid=%b st=%b expected 1 0", m_axis_tvalid, state_dbg);
    end
    step();
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_one_cycle got tvalid=%b expected 0", m_axis_tvalid);
    end
    idle(2);
  endtask

  task automatic test_gapped();
    log2_ratio = 4'd3;
    exp_q.push_back(16'd4);
    for (int i = 1; i <= 8; i++) begin
      send(16'(i));
      if (i == 8) begin
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
          errors++;
          $display("FAIL gapped_valid got tvalid=%b expected 1", m_axis_tvalid);
        end
      end
      idle(1);
    end
    idle(3);
  endtask

  task automatic test_passthrough();
    log2_ratio = 4'd0;
    exp_q.push_back(16'd7);
    exp_q.push_back(16'd16);
    send(16'd7);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'd7) begin
      errors++;
      $display("FAIL pass_first got tvalid=%b tdata=%0d expected 1 7", m_axis_tvalid, m_axis_tdata);
    end
    send(16'd16);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'd16) begin
      errors++;
      $display("FAIL pass_second got tvalid=%b tdata=%0d expected 1 16", m_axis_tvalid, m_axis_tdata);
    end
    idle(1);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL pass_drop got tvalid=%b expected 0", m_axis_tvalid);
    end
    idle(2);
  endtask

  task automatic test_overflow();
    log2_ratio = 4'd1; m_axis_tready = 1'b0;
    send(16'd2); send(16'd4);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'd3 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_first got tvalid=%b tdata=%0d ovf=%b expected 1 3 0",
               m_axis_tvalid, m_axis_tdata, overflow);
    end
    send(16'd6);
    checks++;
    if (m_axis_tdata !== 16'd3) begin
      errors++;
      $display("FAIL ovf_hold got tdata=%0d expected 3", m_axis_tdata);
    end
    send(16'd8);
    s_axis_tvalid = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'd7 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_overwrite got tvalid=%b tdata=%0d ovf=%b expected 1 7 1",
               m_axis_tvalid, m_axis_tdata, overflow);
    end
    clear_overflow = 1'b1; step(); clear_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0 || m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear got ovf=%b tvalid=%b expected 0 1", overflow, m_axis_tvalid);
    end
    exp_q.push_back(16'd7);
    m_axis_tready = 1'b1;
    step();
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drain got tvalid=%b expected 0", m_axis_tvalid);
    end
    // Overflow event coinciding with clear_overflow: set must win.
    m_axis_tready = 1'b0; log2_ratio = 4'd0;
    send(16'd9);
    clear_overflow = 1'b1;
    send(16'd11);
    clear_overflow = 1'b0;
    s_axis_tvalid = 1'b0;
    checks++;
    if (overflow !== 1'b1 || m_axis_tdata !== 16'd11) begin
      errors++;
      $display("FAIL ovf_set_wins got ovf=%b tdata=%0d expected 1 11", overflow, m_axis_tdata);
    end
    clear_overflow = 1'b1; step(); clear_overflow = 1'b0;
    exp_q.push_back(16'd11);
    m_axis_tready = 1'b1;
    idle(2);
    checks++;
    if (overflow !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_final got ovf=%b tvalid=%b expected 0 0", overflow, m_axis_tvalid);
    end
  endtask

  task automatic test_mid_block_change();
    log2_ratio = 4'd2;
    exp_q.push_back(16'd2);   // (1+2+3+4)>>>2
    exp_q.push_back(16'd6);   // (5+7)>>>1
    exp_q.push_back(16'd2);   // (9-4)>>>1
    send(16'd1); send(16'd2);
    log2_ratio = 4'd1;
    send(16'd3);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_latched got tvalid=%b expected 0", m_axis_tvalid);
    end
    send(16'd4);
    send(16'd5); send(16'd7);
    send(16'd9); send(-16'sd4);
    idle(3);
  endtask

  task automatic test_ratio_clamp();
    log2_ratio = 4'd15;
    exp_q.push_back(16'h8000);
    for (int i = 0; i < 256; i++) begin
      send(16'h8000);
      if (i == 254) begin
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
          errors++;
          $display("FAIL clamp_early got tvalid=%b expected 0", m_axis_tvalid);
        end
      end
    end
    s_axis_tvalid = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h8000) begin
      errors++;
      $display("FAIL clamp_result got tvalid=%b tdata=%0d expected 1 -32768",
               m_axis_tvalid, $signed(m_axis_tdata));
    end
    idle(3);
  endtask

  task automatic test_reset_mid_block();
    log2_ratio = 4'd2;
    send(16'd99); send(16'd99); send(16'd99);
    s_axis_tvalid = 1'b0;
    areset = 1'b1;
    #1;
    checks++;
    if (s_axis_tready !== 1'b0 || state_dbg !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async got tready=%b st=%b expected 0 0", s_axis_tready, state_dbg);
    end
    step();
    areset = 1'b0;
    step();
    exp_q.push_back(16'd10);
    for (int i = 0; i < 4; i++) send(16'd10);
    s_axis_tvalid = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'd10) begin
      errors++;
      $display("FAIL midrst_result got tvalid=%b tdata=%0d expected 1 10", m_axis_tvalid, m_axis_tdata);
    end
    idle(4);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    areset = 1'b1; log2_ratio = 4'd0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1; clear_overflow = 1'b0;
    test_reset();
    test_basic();
    test_gapped();
    test_passthrough();
    test_overflow();
    m_axis_tready = 1'b1;
    test_mid_block_change();
    test_ratio_clamp();
    test_reset_mid_block();
    idle(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
